// File: rtl/adder_arb_pkg.sv
// Shared types and constants for the round-robin adder arbiter.
//   DATA_W      : datapath width of the shared adder
//   ID_MAX_W    : widest requester tag supported (NUM_REQ up to 16)
//   adder_req_t : operand pair plus add/subtract select
//   adder_rsp_t : registered result plus requester tag
package adder_arb_pkg;

   localparam int unsigned DATA_W   = 32;
   localparam int unsigned ID_MAX_W = 4;

   typedef struct packed {
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic              sub;
   } adder_req_t;

   typedef struct packed {
      logic [DATA_W-1:0]   sum;
      logic                carry;
      logic                overflow;
      logic [ID_MAX_W-1:0] id;
   } adder_rsp_t;

endpackage

// File: rtl/alu_adder.sv
// Combinational 32-bit two's-complement add/subtract unit.
//   a_i, b_i   : operands
//   sub_i      : 1 = a - b, 0 = a + b
//   sum_o      : result
//   carry_o    : carry out (for subtract, 1 means no borrow)
//   overflow_o : signed overflow
module alu_adder
   import adder_arb_pkg::*;
(
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   input  logic              sub_i,
   output logic [DATA_W-1:0] sum_o,
   output logic              carry_o,
   output logic              overflow_o
);

   logic [DATA_W-1:0] b_eff;
   logic [DATA_W:0]   full;

   // Subtract as a + ~b + 1.
   assign b_eff = sub_i ? ~b_i : b_i;
   assign full  = {1'b0, a_i} + {1'b0, b_eff} + {{DATA_W{1'b0}}, sub_i};

   assign sum_o      = full[DATA_W-1:0];
   assign carry_o    = full[DATA_W];
   assign overflow_o = (a_i[DATA_W-1] == b_eff[DATA_W-1]) &&
                       (sum_o[DATA_W-1] != a_i[DATA_W-1]);

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one alu_adder among NUM_REQ requesters.
//   clk, rst_n                   : clock, asynchronous active-low reset
//   req_valid/req_ready          : per-requester handshake (ready is one-hot or zero)
//   req_a/req_b                  : packed operands, requester i at [32*i +: 32]
//   req_sub                      : per-requester subtract select
//   rsp_valid/rsp_ready          : single-entry result register handshake
//   rsp_sum/carry/overflow/id    : registered result and winning requester
//   busy_cnt                     : count of accepted operations, wraps at 2^16
module adder_arbiter
   import adder_arb_pkg::*;
#(
   parameter int unsigned  NUM_REQ = 4,
   localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*DATA_W-1:0] req_a,
   input  logic [NUM_REQ*DATA_W-1:0] req_b,
   input  logic [NUM_REQ-1:0]        req_sub,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [DATA_W-1:0]         rsp_sum,
   output logic                      rsp_carry,
   output logic                      rsp_overflow,
   output logic [ID_W-1:0]           rsp_id,
   output logic [15:0]               busy_cnt
);

   logic              rsp_valid_q, rsp_valid_d;
   adder_rsp_t        rsp_q, rsp_d;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [15:0]       busy_cnt_q, busy_cnt_d;

   logic              can_accept;
   logic              grant_vld;
   logic [ID_W-1:0]   grant_idx;
   logic              accept;
   adder_req_t        win_req;
   logic [DATA_W-1:0] add_sum;
   logic              add_carry;
   logic              add_ovf;
   logic              unused_id;

   // Draining this cycle frees the slot in the same cycle.
   assign can_accept = !rsp_valid_q || rsp_ready;

   // Round-robin search: first pass covers indices >= rr_ptr, second pass
   // wraps around to the lower indices.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (!grant_vld && req_valid[i] && (ID_W'(i) >= rr_ptr_q)) begin
            grant_vld = 1'b1;
            grant_idx = ID_W'(i);
         end
      end
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (!grant_vld && req_valid[i]) begin
            grant_vld = 1'b1;
            grant_idx = ID_W'(i);
         end
      end
   end

   assign accept = can_accept && grant_vld;

   // Gated by rst_n so no handshake can complete while reset is held.
   always_comb begin
      req_ready = '0;
      if (rst_n && accept) begin
         req_ready[grant_idx] = 1'b1;
      end
   end

   always_comb begin
      win_req.a   = req_a[grant_idx*DATA_W +: DATA_W];
      win_req.b   = req_b[grant_idx*DATA_W +: DATA_W];
      win_req.sub = req_sub[grant_idx];
   end

   alu_adder u_alu_adder (
      .a_i        (win_req.a),
      .b_i        (win_req.b),
      .sub_i      (win_req.sub),
      .sum_o      (add_sum),
      .carry_o    (add_carry),
      .overflow_o (add_ovf)
   );

   always_comb begin
      rsp_valid_d = rsp_valid_q;
      rsp_d       = rsp_q;
      rr_ptr_d    = rr_ptr_q;
      busy_cnt_d  = busy_cnt_q;
      if (accept) begin
         rsp_valid_d    = 1'b1;
         rsp_d.sum      = add_sum;
         rsp_d.carry    = add_carry;
         rsp_d.overflow = add_ovf;
         rsp_d.id       = ID_MAX_W'(grant_idx);
         // Explicit wrap: NUM_REQ need not be a power of two.
         rr_ptr_d       = (32'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + ID_W'(1);
         busy_cnt_d     = busy_cnt_q + 16'd1;
      end else if (rsp_valid_q && rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_q <= 1'b0;
         rsp_q       <= '0;
         rr_ptr_q    <= '0;
         busy_cnt_q  <= '0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         rsp_q       <= rsp_d;
         rr_ptr_q    <= rr_ptr_d;
         busy_cnt_q  <= busy_cnt_d;
      end
   end

   assign rsp_valid    = rsp_valid_q;
   assign rsp_sum      = rsp_q.sum;
   assign rsp_carry    = rsp_q.carry;
   assign rsp_overflow = rsp_q.overflow;
   assign rsp_id       = rsp_q.id[ID_W-1:0];
   assign busy_cnt     = busy_cnt_q;

   // Tag bits above ID_W are always zero.
   assign unused_id = ^rsp_q.id;

endmodule

// File: tb/tb_adder_arbiter.sv
module tb_adder_arbiter;

   localparam int N    = 4;
   localparam int ID_W = $clog2(N);

   logic              clk;
   logic              rst_n;
   logic [N-1:0]      req_valid;
   logic [N-1:0]      req_ready;
   logic [N*32-1:0]   req_a;
   logic [N*32-1:0]   req_b;
   logic [N-1:0]      req_sub;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [31:0]       rsp_sum;
   logic              rsp_carry;
   logic              rsp_overflow;
   logic [ID_W-1:0]   rsp_id;
   logic [15:0]       busy_cnt;

   adder_arbiter #(.NUM_REQ(N)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_a        (req_a),
      .req_b        (req_b),
      .req_sub      (req_sub),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_sum      (rsp_sum),
      .rsp_carry    (rsp_carry),
      .rsp_overflow (rsp_overflow),
      .rsp_id       (rsp_id),
      .busy_cnt     (busy_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state.
   logic        mdl_valid;
   logic [31:0] mdl_sum;
   logic        mdl_carry;
   logic        mdl_ovf;
   int          mdl_id;
   int          mdl_ptr;
   logic [15:0] mdl_cnt;
   int          mdl_g;
   int          waits [N];

   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -64'sd2147483648;

   typedef struct {
      int          idx;
      logic [31:0] a;
      logic [31:0] b;
      logic        sub;
      logic [31:0] sum;
      logic        c;
      logic        v;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic mdl_reset();
      mdl_valid = 1'b0;
      mdl_sum   = '0;
      mdl_carry = 1'b0;
      mdl_ovf   = 1'b0;
      mdl_id    = 0;
      mdl_ptr   = 0;
      mdl_cnt   = '0;
      mdl_g     = -1;
   endtask

   // Signed/unsigned semantics computed with 64-bit arithmetic.
   task automatic ref_alu(input logic [31:0] a, input logic [31:0] b, input logic sub,
                          output logic [31:0] s, output logic c, output logic v);
      longint sa, sb, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (sub) begin
         r = sa - sb;
         s = a - b;
         c = (a >= b);
      end else begin
         r = sa + sb;
         s = a + b;
         c = ((longint'(a) + longint'(b)) > 64'sd4294967295);
      end
      v = (r > SMAX) || (r < SMIN);
   endtask

   function automatic int mdl_pick();
      if (mdl_valid && !rsp_ready) return -1;
      for (int k = 0; k < N; k++) begin
         if (req_valid[(mdl_ptr + k) % N]) return (mdl_ptr + k) % N;
      end
      return -1;
   endfunction

   function automatic logic [31:0] rand_op();
      case ($urandom_range(0, 5))
         0:       return 32'h7FFF_FFFF;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h0;
         default: return $urandom();
      endcase
   endfunction

   task automatic set_slot(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic sub);
      req_a[32*i +: 32] = a;
      req_b[32*i +: 32] = b;
      req_sub[i]        = sub;
   endtask

   // Called just after a rising edge with inputs already driven.
   task automatic cycle();
      logic [31:0]  s;
      logic         c, v;
      logic [N-1:0] er;
      @(negedge clk);
      mdl_g = mdl_pick();
      er = '0;
      if (mdl_g >= 0) er[mdl_g] = 1'b1;
      chk("req_ready", req_ready, er);
      @(posedge clk);
      if (mdl_g >= 0) begin
         ref_alu(req_a[32*mdl_g +: 32], req_b[32*mdl_g +: 32], req_sub[mdl_g], s, c, v);
         mdl_sum   = s;
         mdl_carry = c;
         mdl_ovf   = v;
         mdl_valid = 1'b1;
         mdl_id    = mdl_g;
         mdl_ptr   = (mdl_g + 1) % N;
         mdl_cnt   = mdl_cnt + 16'd1;
      end else if (mdl_valid && rsp_ready) begin
         mdl_valid = 1'b0;
      end
      #1;
      chk("rsp_valid", rsp_valid, mdl_valid);
      chk("rsp_sum", rsp_sum, mdl_sum);
      chk("rsp_carry", rsp_carry, mdl_carry);
      chk("rsp_overflow", rsp_overflow, mdl_ovf);
      chk("rsp_id", rsp_id, mdl_id);
      chk("busy_cnt", busy_cnt, mdl_cnt);
   endtask

   initial begin
      vecs[0] = '{2, 32'h7FFF_FFFF, 32'h1,         1'b0, 32'h8000_0000, 1'b0, 1'b1};
      vecs[1] = '{1, 32'h5,         32'h7,         1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
      vecs[2] = '{1, 32'h8000_0000, 32'h1,         1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
      vecs[3] = '{3, 32'hFFFF_FFFF, 32'h1,         1'b0, 32'h0,         1'b1, 1'b0};
      vecs[4] = '{0, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0,         1'b1, 1'b1};
      vecs[5] = '{0, 32'h0,         32'h0,         1'b1, 32'h0,         1'b1, 1'b0};
      vecs[6] = '{2, 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0};
      vecs[7] = '{3, 32'h0,         32'h1,         1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
      vecs[8] = '{1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 1'b0, 1'b1};

      // Reset held with every requester asking.
      rst_n     = 1'b0;
      req_valid = '1;
      req_a     = '0;
      req_b     = '0;
      req_sub   = '0;
      rsp_ready = 1'b1;
      mdl_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_busy_cnt", busy_cnt, 0);
      chk("rst_rsp_sum", rsp_sum, 0);
      chk("rst_rsp_id", rsp_id, 0);
      rst_n = 1'b1;
      #1;
      chk("first_grant", req_ready, 4'b0001);

      // Round-robin rotation with all requesters valid.
      for (int k = 0; k < 6; k++) begin
         for (int i = 0; i < N; i++) set_slot(i, $urandom(), $urandom(), 1'($urandom_range(0, 1)));
         cycle();
         chk("rr_id", rsp_id, k % N);
         chk("rr_busy", busy_cnt, k + 1);
      end

      // Directed single-requester vectors.
      foreach (vecs[j]) begin
         req_valid = '0;
         req_valid[vecs[j].idx] = 1'b1;
         set_slot(vecs[j].idx, vecs[j].a, vecs[j].b, vecs[j].sub);
         cycle();
         chk("vec_valid", rsp_valid, 1);
         chk("vec_sum", rsp_sum, vecs[j].sum);
         chk("vec_carry", rsp_carry, vecs[j].c);
         chk("vec_ovf", rsp_overflow, vecs[j].v);
         chk("vec_id", rsp_id, vecs[j].idx);
      end

      // Backpressure with id=1, sum=0x10 pending.
      req_valid = 4'b0010;
      set_slot(1, 32'h8, 32'h8, 1'b0);
      cycle();
      rsp_ready = 1'b0;
      req_valid = '1;
      for (int i = 0; i < N; i++) set_slot(i, $urandom(), $urandom(), 1'($urandom_range(0, 1)));
      for (int k = 0; k < 3; k++) begin
         cycle();
         chk("bp_ready", req_ready, 0);
         chk("bp_valid", rsp_valid, 1);
         chk("bp_id", rsp_id, 1);
         chk("bp_sum", rsp_sum, 32'h10);
      end
      rsp_ready = 1'b1;
      #1;
      chk("bp_release_ready", req_ready, 4'b0100);
      cycle();
      chk("bp_release_id", rsp_id, 2);

      // Randomised traffic; unaccepted requests hold their operands.
      for (int i = 0; i < N; i++) waits[i] = 0;
      for (int t = 0; t < 400; t++) begin
         for (int i = 0; i < N; i++) begin
            if (!(req_valid[i] && mdl_g != i)) begin
               req_valid[i] = ($urandom_range(0, 2) != 0);
               set_slot(i, rand_op(), rand_op(), 1'($urandom_range(0, 1)));
               waits[i] = 0;
            end
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         cycle();
         if (mdl_g >= 0) begin
            chk("fair_wait", waits[mdl_g] < N, 1);
            waits[mdl_g] = 0;
            for (int i = 0; i < N; i++) if (i != mdl_g && req_valid[i]) waits[i]++;
         end
      end

      // busy_cnt wrap.
      rst_n = 1'b0;
      req_valid = 4'b0001;
      set_slot(0, 32'h1, 32'h1, 1'b0);
      rsp_ready = 1'b1;
      #2;
      rst_n = 1'b1;
      repeat (65535) @(posedge clk);
      #1;
      chk("pre_wrap_cnt", busy_cnt, 16'hFFFF);
      mdl_reset();
      mdl_valid = 1'b1;
      mdl_sum   = 32'h2;
      mdl_ptr   = 1;
      mdl_cnt   = 16'hFFFF;
      cycle();
      chk("wrap_cnt", busy_cnt, 0);

      // Asynchronous reset between edges with a result pending.
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rsp_valid", rsp_valid, 0);
      chk("async_busy_cnt", busy_cnt, 0);
      chk("async_rsp_sum", rsp_sum, 0);
      chk("async_ready", req_ready, 0);
      req_valid = '1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      mdl_reset();
      #1;
      chk("restart_grant", req_ready, 4'b0001);
      cycle();
      chk("restart_id", rsp_id, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
